// File: rtl/fm_pkg.sv
// Shared constants for the FM operator sequencer and datapath.
// Stage encodings here are the single source of truth for both blocks.
package fm_pkg;
    localparam int NUM_OPS = 36;
    localparam int STAGES  = 3;
    localparam int ACC_W   = 19;
    localparam int OP_W    = 6;
    localparam int RES_W   = 13;

    typedef enum logic [1:0] {
        ST_LOGSIN = 2'd0,
        ST_EXP    = 2'd1,
        ST_RESULT = 2'd2
    } stage_e;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    function automatic logic signed [ACC_W-1:0] sext_result(input logic [RES_W-1:0] r);
        return {{(ACC_W-RES_W){r[RES_W-1]}}, r};
    endfunction
endpackage

// File: rtl/fm_mix_sat.sv
// Clamp a signed mix accumulator to 13 bits, then scale by 8 to 16-bit audio.
// Purely combinational; zero latency, no flow control.
module fm_mix_sat
    import fm_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [15:0]      sat_o
);
    localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'(4095);
    localparam logic signed [ACC_W-1:0] LIM_LO = ACC_W'(-4096);

    logic signed [12:0] clamped;

    always_comb begin
        if (acc_i > LIM_HI) begin
            clamped = 13'h0FFF;
        end else if (acc_i < LIM_LO) begin
            clamped = 13'h1000;
        end else begin
            clamped = acc_i[12:0];
        end
    end

    assign sat_o = {clamped, 3'b000};
endmodule

// File: rtl/fm_op_sequencer.sv
// Steps the shared FM operator datapath through every slot once per sample tick
// and mixes carrier results into saturated left/right audio at frame end.
module fm_op_sequencer
    import fm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    output logic [OP_W-1:0]  op_sel,
    output logic [1:0]       stage,
    output logic             op_done,
    input  logic [RES_W-1:0] op_result,
    input  logic             op_carrier,
    input  logic             ch_cha,
    input  logic             ch_chb,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic [15:0]      audio_l,
    output logic [15:0]      audio_r
);
    seq_state_e              state_q;
    stage_e                  stage_q;
    logic [OP_W-1:0]         op_sel_q;
    logic                    op_done_q;
    logic                    busy_q;
    logic                    frame_done_q;
    logic                    overrun_q;
    logic [15:0]             audio_l_q;
    logic [15:0]             audio_r_q;
    logic signed [ACC_W-1:0] acc_l_q;
    logic signed [ACC_W-1:0] acc_r_q;
    logic signed [ACC_W-1:0] acc_l_d;
    logic signed [ACC_W-1:0] acc_r_d;
    logic signed [15:0]      sat_l;
    logic signed [15:0]      sat_r;
    logic                    last_slot;

    // acc_x_d already includes the current slot, so the final slot is mixed in before latching
    always_comb begin
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        if (op_done_q && op_carrier) begin
            if (ch_cha) acc_l_d = acc_l_q + sext_result(op_result);
            if (ch_chb) acc_r_d = acc_r_q + sext_result(op_result);
        end
    end

    assign last_slot = op_done_q && (op_sel_q == OP_W'(NUM_OPS-1));

    fm_mix_sat u_sat_l (.acc_i(acc_l_d), .sat_o(sat_l));
    fm_mix_sat u_sat_r (.acc_i(acc_r_d), .sat_o(sat_r));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SEQ_IDLE;
            stage_q      <= ST_LOGSIN;
            op_sel_q     <= '0;
            op_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            audio_l_q    <= '0;
            audio_r_q    <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (sample_tick) begin
                        state_q   <= SEQ_RUN;
                        busy_q    <= 1'b1;
                        stage_q   <= ST_LOGSIN;
                        op_sel_q  <= '0;
                        op_done_q <= 1'b0;
                    end
                end
                SEQ_RUN: begin
                    // ticks are only honoured in IDLE; a dropped one is flagged
                    overrun_q <= sample_tick;
                    if (last_slot) begin
                        state_q      <= SEQ_IDLE;
                        busy_q       <= 1'b0;
                        stage_q      <= ST_LOGSIN;
                        op_sel_q     <= '0;
                        op_done_q    <= 1'b0;
                        frame_done_q <= 1'b1;
                        audio_l_q    <= sat_l;
                        audio_r_q    <= sat_r;
                        acc_l_q      <= '0;
                        acc_r_q      <= '0;
                    end else begin
                        acc_l_q <= acc_l_d;
                        acc_r_q <= acc_r_d;
                        case (stage_q)
                            ST_LOGSIN: begin
                                stage_q   <= ST_EXP;
                                op_done_q <= 1'b0;
                            end
                            ST_EXP: begin
                                stage_q   <= ST_RESULT;
                                op_done_q <= 1'b1;
                            end
                            default: begin
                                stage_q   <= ST_LOGSIN;
                                op_done_q <= 1'b0;
                                op_sel_q  <= op_sel_q + OP_W'(1);
                            end
                        endcase
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign op_sel     = op_sel_q;
    assign stage      = stage_q;
    assign op_done    = op_done_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign audio_l    = audio_l_q;
    assign audio_r    = audio_r_q;
endmodule

// File: tb/tb_fm_op_sequencer.sv
// Directed bench for fm_op_sequencer: frame timing, mixing, saturation,
// dropped ticks, mid-frame reset and back-to-back frames.
module tb_fm_op_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [5:0]  op_sel;
    logic [1:0]  stage;
    logic        op_done;
    logic [12:0] op_result;
    logic        op_carrier;
    logic        ch_cha;
    logic        ch_chb;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [15:0] audio_l;
    logic [15:0] audio_r;

    logic        car_tab [64];
    logic [12:0] res_tab [64];
    logic        cha_en;
    logic        chb_en;

    int total = 0;
    int bad   = 0;

    int          nbusy, nfd, nov, nseq, ncyc, nhold;
    logic [15:0] fd_l, fd_r;

    always #5 clk = ~clk;

    // datapath stub: per-slot result/carrier tables
    assign op_result  = res_tab[op_sel];
    assign op_carrier = car_tab[op_sel];
    assign ch_cha     = cha_en;
    assign ch_chb     = chb_en;

    fm_op_sequencer dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .op_sel(op_sel), .stage(stage), .op_done(op_done),
        .op_result(op_result), .op_carrier(op_carrier),
        .ch_cha(ch_cha), .ch_chb(ch_chb),
        .busy(busy), .frame_done(frame_done), .overrun(overrun),
        .audio_l(audio_l), .audio_r(audio_r)
    );

    function automatic logic [31:0] sx16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic set_slots(input logic car, input logic [12:0] res);
        for (int i = 0; i < 64; i++) begin
            car_tab[i] = car;
            res_tab[i] = res;
        end
    endtask

    // Pulse a tick, then run a fixed window; optional extra ticks at frame cycles t1/t2.
    task automatic run_frame(input int t1, input int t2);
        nbusy = 0; nfd = 0; nov = 0; nseq = 0;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int c = 0; c < 130; c++) begin
            if (busy) begin
                if (op_sel !== 6'(nbusy / 3) || stage !== 2'(nbusy % 3) ||
                    op_done !== ((nbusy % 3) == 2)) nseq++;
                sample_tick = (nbusy == t1) || (nbusy == t2);
                nbusy++;
            end else begin
                sample_tick = 1'b0;
            end
            if (overrun) nov++;
            if (frame_done) begin
                nfd++;
                fd_l = audio_l;
                fd_r = audio_r;
                if (op_sel !== 6'd0) nseq++;
            end
            @(posedge clk); #1;
        end
        sample_tick = 1'b0;
    endtask

    // Pulse a tick and wait (bounded) for frame_done; audio_l must hold meanwhile.
    task automatic start_and_wait(input logic [15:0] held);
        ncyc = 0; nov = 0; nhold = 0;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        while (!frame_done && ncyc < 150) begin
            if (overrun) nov++;
            if (audio_l !== held) nhold++;
            ncyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0;
        cha_en = 1'b0; chb_en = 1'b0;
        set_slots(1'b0, 13'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_sel", 32'(op_sel), 32'd0);
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_op_done", 32'(op_done), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_audio_l", 32'(audio_l), 32'd0);
        check("rst_audio_r", 32'(audio_r), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // plain frame, no carriers
        run_frame(-1, -1);
        check("t1_busy_cycles", 32'(nbusy), 32'd108);
        check("t1_sequence_errs", 32'(nseq), 32'd0);
        check("t1_frame_done_cnt", 32'(nfd), 32'd1);
        check("t1_overrun_cnt", 32'(nov), 32'd0);
        check("t1_op_sel_after", 32'(op_sel), 32'd0);
        check("t1_audio_l", sx16(fd_l), 32'd0);

        // carriers on slots 1 and 3, left only: (1000+500)*8
        set_slots(1'b0, 13'd0);
        car_tab[1] = 1'b1; res_tab[1] = 13'd1000;
        car_tab[3] = 1'b1; res_tab[3] = 13'd500;
        res_tab[2] = 13'd777;
        cha_en = 1'b1; chb_en = 1'b0;
        run_frame(-1, -1);
        check("t2_audio_l", sx16(fd_l), 32'd12000);
        check("t2_audio_r", sx16(fd_r), 32'd0);
        check("t2_hold_l", sx16(audio_l), 32'd12000);

        // all carriers at positive full scale, both channels
        set_slots(1'b1, 13'h0FFF);
        cha_en = 1'b1; chb_en = 1'b1;
        run_frame(-1, -1);
        check("t3_pos_sat_l", sx16(fd_l), 32'd32760);
        check("t3_pos_sat_r", sx16(fd_r), 32'd32760);

        set_slots(1'b1, 13'h1000);
        run_frame(-1, -1);
        check("t3_neg_sat_l", sx16(fd_l), 32'hFFFF8000);
        check("t3_neg_sat_r", sx16(fd_r), 32'hFFFF8000);

        // ticks during a frame, including the final op_done cycle, are dropped
        set_slots(1'b1, 13'd10);
        run_frame(50, 107);
        check("t4_overrun_cnt", 32'(nov), 32'd2);
        check("t4_busy_cycles", 32'(nbusy), 32'd108);
        check("t4_frame_done_cnt", 32'(nfd), 32'd1);
        check("t4_audio_l", sx16(fd_l), 32'd2880);

        // reset mid-frame with live accumulators
        set_slots(1'b1, 13'd100);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("t5_busy_pre_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_busy_after_reset", 32'(busy), 32'd0);
        check("t5_audio_l_after_reset", sx16(audio_l), 32'd0);
        set_slots(1'b0, 13'd100);
        run_frame(-1, -1);
        check("t5_busy_cycles", 32'(nbusy), 32'd108);
        check("t5_audio_l", sx16(fd_l), 32'd0);
        check("t5_audio_r", sx16(fd_r), 32'd0);

        // back-to-back frames, next tick one cycle after frame_done
        set_slots(1'b0, 13'd0);
        car_tab[0] = 1'b1; res_tab[0] = 13'd8;
        cha_en = 1'b1; chb_en = 1'b0;
        start_and_wait(16'd0);
        check("t6a_frame_done", 32'(frame_done), 32'd1);
        check("t6a_cycles", 32'(ncyc), 32'd108);
        check("t6a_audio_l", sx16(audio_l), 32'd64);
        check("t6a_overrun_cnt", 32'(nov), 32'd0);
        res_tab[0] = 13'd16;
        @(posedge clk); #1;
        check("t6_gap_overrun", 32'(overrun), 32'd0);
        start_and_wait(16'd64);
        check("t6b_frame_done", 32'(frame_done), 32'd1);
        check("t6b_cycles", 32'(ncyc), 32'd108);
        check("t6b_audio_hold_errs", 32'(nhold), 32'd0);
        check("t6b_overrun_cnt", 32'(nov), 32'd0);
        check("t6b_audio_l", sx16(audio_l), 32'd128);
        @(posedge clk); #1;
        check("t6b_overrun_after", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
